// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fc_pkg
// Purpose  : Shared flow-control types, FSM encoding and modulo credit helpers.
// Revision : 1.0 - initial release
// ============================================================================
package fc_pkg;

    localparam int FC_HDR_W = 8;
    localparam int FC_DAT_W = 12;

    typedef logic [FC_HDR_W-1:0] fc_hdr_t;
    typedef logic [FC_DAT_W-1:0] fc_dat_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } upd_state_t;

    // Half of the modulo space: a gap at or above this means the peer overran us.
    function automatic logic [31:0] fc_half(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

    function automatic logic [31:0] fc_gap(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int unsigned w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return (a - b) & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rx_fc_credit_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : rx_fc_credit_ctrl_if
// Purpose  : Receive/free/UpdateFC signal bundle of the RX credit manager.
// Revision : 1.0 - initial release
// ============================================================================
interface rx_fc_credit_ctrl_if
    import fc_pkg::*;
#(
    parameter int HDR_W = FC_HDR_W,
    parameter int DAT_W = FC_DAT_W
) ();

    logic             tlp_rx_valid;
    logic [DAT_W-1:0] tlp_rx_dcred;
    logic             buf_free_valid;
    logic [DAT_W-1:0] buf_free_dcred;
    logic             updfc_req;
    logic [HDR_W-1:0] updfc_hdr;
    logic [DAT_W-1:0] updfc_dat;
    logic             updfc_ack;
    logic [HDR_W-1:0] ca_hdr;
    logic [DAT_W-1:0] ca_dat;
    logic             overflow_err;
    logic [DAT_W-1:0] credits_avail_dat;

    modport master (
        output tlp_rx_valid, tlp_rx_dcred, buf_free_valid, buf_free_dcred, updfc_ack,
        input  updfc_req, updfc_hdr, updfc_dat, ca_hdr, ca_dat, overflow_err,
               credits_avail_dat
    );

    modport slave (
        input  tlp_rx_valid, tlp_rx_dcred, buf_free_valid, buf_free_dcred, updfc_ack,
        output updfc_req, updfc_hdr, updfc_dat, ca_hdr, ca_dat, overflow_err,
               credits_avail_dat
    );

endinterface
`default_nettype wire

// File: rtl/fc_updfc_sched.sv
`default_nettype none
// ============================================================================
// Module   : fc_updfc_sched
// Purpose  : Accumulates freed credits and schedules UpdateFC requests.
// Revision : 1.0 - initial release
// ============================================================================
module fc_updfc_sched
    import fc_pkg::*;
#(
    parameter int HDR_W       = FC_HDR_W,
    parameter int DAT_W       = FC_DAT_W,
    parameter int HDR_INIT    = 32,
    parameter int UPD_THRESH  = 8,
    parameter int UPD_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             free_valid,
    input  logic [DAT_W-1:0] free_dcred,
    input  logic [HDR_W-1:0] ca_hdr_nxt,
    input  logic [DAT_W-1:0] ca_dat_nxt,
    input  logic             ack,
    output logic             req,
    output logic [HDR_W-1:0] upd_hdr,
    output logic [DAT_W-1:0] upd_dat
);

    localparam int               TMR_W    = $clog2(UPD_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(UPD_TIMEOUT);
    localparam logic [HDR_W-1:0] HDR_TRIG = HDR_W'(HDR_INIT / 2);
    localparam logic [DAT_W-1:0] DAT_TRIG = DAT_W'(UPD_THRESH);

    upd_state_t       r_state, w_state_nxt;
    logic [HDR_W-1:0] r_pend_hdr, w_pend_hdr_nxt;
    logic [DAT_W-1:0] r_pend_dat, w_pend_dat_nxt;
    logic [HDR_W-1:0] r_upd_hdr, w_upd_hdr_nxt;
    logic [DAT_W-1:0] r_upd_dat, w_upd_dat_nxt;
    logic [TMR_W-1:0] r_timer, w_timer_nxt;
    logic             w_pend_any;
    logic             w_fire;

    assign w_pend_any = (r_pend_hdr != '0) || (r_pend_dat != '0);
    assign w_fire     = w_pend_any && ((r_pend_dat >= DAT_TRIG) ||
                                       (r_pend_hdr >= HDR_TRIG) ||
                                       (r_timer == TMR_MAX));

    always_comb begin
        w_state_nxt    = r_state;
        w_pend_hdr_nxt = r_pend_hdr + {{(HDR_W-1){1'b0}}, free_valid};
        w_pend_dat_nxt = r_pend_dat + (free_valid ? free_dcred : '0);
        w_upd_hdr_nxt  = r_upd_hdr;
        w_upd_dat_nxt  = r_upd_dat;
        w_timer_nxt    = r_timer;
        case (r_state)
            IDLE: begin
                if (w_fire) begin
                    // A free in this same cycle is already folded into ca_*_nxt.
                    w_state_nxt    = REQ;
                    w_pend_hdr_nxt = '0;
                    w_pend_dat_nxt = '0;
                    w_timer_nxt    = '0;
                    w_upd_hdr_nxt  = ca_hdr_nxt;
                    w_upd_dat_nxt  = ca_dat_nxt;
                end else if (w_pend_any && (r_timer != TMR_MAX)) begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            REQ: begin
                if (ack) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pend_hdr <= '0;
            r_pend_dat <= '0;
            r_upd_hdr  <= '0;
            r_upd_dat  <= '0;
            r_timer    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pend_hdr <= w_pend_hdr_nxt;
            r_pend_dat <= w_pend_dat_nxt;
            r_upd_hdr  <= w_upd_hdr_nxt;
            r_upd_dat  <= w_upd_dat_nxt;
            r_timer    <= w_timer_nxt;
        end
    end

    assign req     = (r_state == REQ);
    assign upd_hdr = r_upd_hdr;
    assign upd_dat = r_upd_dat;

endmodule
`default_nettype wire

// File: rtl/rx_fc_credit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rx_fc_credit_ctrl
// Purpose  : Receiver CA/CR credit tracking, overflow detection and UpdateFC.
// Revision : 1.0 - initial release
// ============================================================================
module rx_fc_credit_ctrl
    import fc_pkg::*;
#(
    parameter int HDR_W       = FC_HDR_W,
    parameter int DAT_W       = FC_DAT_W,
    parameter int HDR_INIT    = 32,
    parameter int DAT_INIT    = 256,
    parameter int UPD_THRESH  = 8,
    parameter int UPD_TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    rx_fc_credit_ctrl_if.slave  bus
);

    logic [HDR_W-1:0] r_ca_hdr, r_cr_hdr, w_ca_hdr_nxt, w_cr_hdr_nxt;
    logic [DAT_W-1:0] r_ca_dat, r_cr_dat, w_ca_dat_nxt, w_cr_dat_nxt;
    logic             r_ovf, w_ovf_nxt;

    always_comb begin
        w_cr_hdr_nxt = r_cr_hdr + {{(HDR_W-1){1'b0}}, bus.tlp_rx_valid};
        w_cr_dat_nxt = r_cr_dat + (bus.tlp_rx_valid ? bus.tlp_rx_dcred : '0);
        w_ca_hdr_nxt = r_ca_hdr + {{(HDR_W-1){1'b0}}, bus.buf_free_valid};
        w_ca_dat_nxt = r_ca_dat + (bus.buf_free_valid ? bus.buf_free_dcred : '0);
        // Judged on the values being written this edge so the flag lands with CR.
        w_ovf_nxt = r_ovf ||
            (fc_gap(32'(w_ca_hdr_nxt), 32'(w_cr_hdr_nxt), HDR_W) >= fc_half(HDR_W)) ||
            (fc_gap(32'(w_ca_dat_nxt), 32'(w_cr_dat_nxt), DAT_W) >= fc_half(DAT_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ca_hdr <= HDR_W'(HDR_INIT);
            r_ca_dat <= DAT_W'(DAT_INIT);
            r_cr_hdr <= '0;
            r_cr_dat <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_ca_hdr <= w_ca_hdr_nxt;
            r_ca_dat <= w_ca_dat_nxt;
            r_cr_hdr <= w_cr_hdr_nxt;
            r_cr_dat <= w_cr_dat_nxt;
            r_ovf    <= w_ovf_nxt;
        end
    end

    fc_updfc_sched #(
        .HDR_W       (HDR_W),
        .DAT_W       (DAT_W),
        .HDR_INIT    (HDR_INIT),
        .UPD_THRESH  (UPD_THRESH),
        .UPD_TIMEOUT (UPD_TIMEOUT)
    ) u_sched (
        .clk        (clk),
        .rst_n      (rst_n),
        .free_valid (bus.buf_free_valid),
        .free_dcred (bus.buf_free_dcred),
        .ca_hdr_nxt (w_ca_hdr_nxt),
        .ca_dat_nxt (w_ca_dat_nxt),
        .ack        (bus.updfc_ack),
        .req        (bus.updfc_req),
        .upd_hdr    (bus.updfc_hdr),
        .upd_dat    (bus.updfc_dat)
    );

    assign bus.ca_hdr            = r_ca_hdr;
    assign bus.ca_dat            = r_ca_dat;
    assign bus.overflow_err      = r_ovf;
    assign bus.credits_avail_dat = DAT_W'(fc_gap(32'(r_ca_dat), 32'(r_cr_dat), DAT_W));

endmodule
`default_nettype wire
